// File: rtl/ysyx_clint_timer_pkg.sv
// Shared bus addresses, AXI response codes and read-FSM state encoding for the
// CLINT machine timer.
package ysyx_clint_timer_pkg;

    localparam logic [31:0] ysyx_BUS_RTC_ADDR    = 32'ha000_0048;
    localparam logic [31:0] ysyx_BUS_RTC_ADDR_UP = 32'ha000_004c;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ysyx_clint_mtime.sv
// Free-running 64-bit mtime counter with a snapshot register that latches the
// current count when capture_i is high.
module ysyx_clint_mtime (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_i,
    output logic [63:0] mtime_o,
    output logic [63:0] snap_o
);

    logic [63:0] mtime_q;
    logic [63:0] snap_q;
    logic [63:0] snap_d;
    wire  [63:0] mtime_d;

    // Natural 64-bit overflow gives the wrap from all-ones back to zero.
    assign mtime_d = mtime_q + 64'd1;

    always_comb begin
        snap_d = snap_q;
        if (capture_i) begin
            snap_d = mtime_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q <= 64'd0;
            snap_q  <= 64'd0;
        end else begin
            mtime_q <= mtime_d;
            snap_q  <= snap_d;
        end
    end

    assign mtime_o = mtime_q;
    assign snap_o  = snap_q;

endmodule

// File: rtl/ysyx_clint_timer.sv
// Read-mostly CLINT timer slave: single-beat AXI-style reads of mtime, writes
// acknowledged and discarded.
module ysyx_clint_timer
    import ysyx_clint_timer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        arburst,
    input  logic [2:0]        arsize,
    input  logic [7:0]        arlen,
    input  logic [3:0]        arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready_o,
    output logic [3:0]        rid,
    output logic              rlast_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready,
    input  logic [1:0]        awburst,
    input  logic [2:0]        awsize,
    input  logic [7:0]        awlen,
    input  logic [3:0]        awid,
    input  logic              wlast,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready_o,
    output logic [3:0]        bid,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; once raised, rvalid_o/bvalid_o and their payload hold until accepted.

    logic unused_inputs;
    assign unused_inputs = ^{arburst, arsize, arlen, arid, awburst, awsize, awlen,
                             awid, wlast, awaddr, wdata, wstrb};

    rd_state_e         rd_state_q, rd_state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              bvalid_q, bvalid_d;

    logic        ar_hs;
    logic        hit_lo;
    logic        hit_up;
    logic        aw_hs;
    logic [63:0] mtime;
    logic [63:0] snap;

    assign hit_lo = (araddr == ADDR_W'(ysyx_BUS_RTC_ADDR));
    assign hit_up = (araddr == ADDR_W'(ysyx_BUS_RTC_ADDR_UP));
    assign ar_hs  = arvalid && (rd_state_q == R_IDLE);

    // Reading the high word freezes the full count so the later low read matches it.
    ysyx_clint_mtime u_mtime (
        .clk       (clk),
        .rst       (rst),
        .capture_i (ar_hs && hit_up),
        .mtime_o   (mtime),
        .snap_o    (snap)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rd_state_d = R_RESP;
                    if (hit_up) begin
                        rdata_d = DATA_W'(mtime[63:32]);
                        rresp_d = AXI_RESP_OKAY;
                    end else if (hit_lo) begin
                        rdata_d = DATA_W'(snap[31:0]);
                        rresp_d = AXI_RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = AXI_RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Writes need both channels together; a lone address or data beat is ignored.
    assign aw_hs = awvalid && wvalid && !bvalid_q;

    always_comb begin
        bvalid_d = bvalid_q;
        if (bvalid_q) begin
            bvalid_d = !bready;
        end else if (aw_hs) begin
            bvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
            bvalid_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bvalid_q   <= bvalid_d;
        end
    end

    assign arready_o = (rd_state_q == R_IDLE);
    assign rvalid_o  = (rd_state_q == R_RESP);
    assign rlast_o   = rvalid_o;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rid       = 4'd0;
    assign awready_o = !bvalid_q;
    assign wready_o  = !bvalid_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = AXI_RESP_OKAY;
    assign bid       = 4'd0;

endmodule

// File: tb/tb_ysyx_clint_timer.sv
// Self-checking bench for ysyx_clint_timer: reference cycle model plus a
// read-response scoreboard, table-driven reads and hand-written corner cases.
module tb_ysyx_clint_timer;

  localparam logic [31:0] LO_ADDR = 32'ha000_0048;
  localparam logic [31:0] UP_ADDR = 32'ha000_004c;

  logic        clk;
  logic        rst;
  logic [1:0]  arburst, awburst;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic        arvalid, arready_o;
  logic [3:0]  rid, bid;
  logic        rlast_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o, bresp_o;
  logic        rvalid_o, rready;
  logic        wlast, awvalid, awready_o;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready_o;
  logic        bvalid_o, bready;

  ysyx_clint_timer dut (
    .clk(clk), .rst(rst),
    .arburst(arburst), .arsize(arsize), .arlen(arlen), .arid(arid),
    .araddr(araddr), .arvalid(arvalid), .arready_o(arready_o),
    .rid(rid), .rlast_o(rlast_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rvalid_o(rvalid_o), .rready(rready),
    .awburst(awburst), .awsize(awsize), .awlen(awlen), .awid(awid), .wlast(wlast),
    .awaddr(awaddr), .awvalid(awvalid), .awready_o(awready_o),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready_o(wready_o),
    .bid(bid), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready)
  );

  // ---------------- clock / reference model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] m_time;
  logic [63:0] m_snap;
  logic        load_en;
  logic [63:0] load_v;
  logic [63:0] cyc;

  initial begin
    m_time = '0;
    cyc    = '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 64'd1;
    if (rst)          m_time <= '0;
    else if (load_en) m_time <= load_v;
    else              m_time <= m_time + 64'd1;
  end

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_total;
  logic [33:0] exp_q[$];
  logic [63:0] last_up_time;
  logic [63:0] last_up_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic start_read(input logic [31:0] addr);
    int n;
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arready_o) check("arready_wait", {63'd0, arready_o}, 64'd1);
    if (addr == UP_ADDR) begin
      m_snap       = m_time;
      last_up_time = m_time;
      last_up_cyc  = cyc;
      exp_q.push_back({2'b00, m_time[63:32]});
    end else if (addr == LO_ADDR) begin
      exp_q.push_back({2'b00, m_snap[31:0]});
    end else begin
      exp_q.push_back({2'b10, 32'd0});
    end
    @(negedge clk);
    arvalid = 1'b0;
    check("r_latency", {63'd0, rvalid_o}, 64'd1);
  endtask

  task automatic finish_read(output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic [33:0] e;
    n = 0;
    while (!rvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    rready = 1'b1;
    data = rdata_o;
    resp = rresp_o;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("rdata", 64'(rdata_o), 64'(e[31:0]));
      check("rresp", 64'(rresp_o), 64'(e[33:32]));
    end
    check("rlast_rid", {59'd0, rlast_o, rid}, {59'd0, 1'b1, 4'd0});
    @(negedge clk);
    rready = 1'b0;
    check("r_done", {62'd0, rvalid_o, arready_o}, 64'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    start_read(addr);
    finish_read(data, resp);
  endtask

  task automatic read64(output logic [63:0] val);
    logic [31:0] hi, lo;
    logic [1:0]  r;
    do_read(UP_ADDR, hi, r);
    do_read(LO_ADDR, lo, r);
    val = {hi, lo};
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [63:0] v1, v2, t1, c1, c_rel;
    logic [31:0] d, d0;
    logic [1:0]  r;

    vecs[0] = '{UP_ADDR,      2'b00};
    vecs[1] = '{LO_ADDR,      2'b00};
    vecs[2] = '{32'ha000_0050, 2'b10};
    vecs[3] = '{32'ha000_0044, 2'b10};
    vecs[4] = '{32'h0000_0048, 2'b10};
    vecs[5] = '{32'ha100_0048, 2'b10};
    vecs[6] = '{32'ha000_0049, 2'b10};
    vecs[7] = '{LO_ADDR,      2'b00};

    n_pass = 0; n_total = 0;
    rst = 1'b1; load_en = 1'b0; load_v = '0; m_snap = '0;
    arburst = 2'b01; arsize = 3'd2; arlen = 8'd0; arid = 4'd5;
    awburst = 2'b01; awsize = 3'd2; awlen = 8'd0; awid = 4'd3; wlast = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {61'd0, arready_o, awready_o, wready_o}, 64'd7);
    check("rst_valid", {62'd0, rvalid_o, bvalid_o}, 64'd0);
    check("rst_data", {rdata_o, 2'b00, rresp_o, bresp_o, rid, bid}, 64'd0);
    rst = 1'b0;
    c_rel = cyc;

    // Counter after reset: value equals cycles since release
    read64(v1);
    check("rst_hi_zero", 64'(v1[63:32]), 64'd0);
    check("rst_count", v1, last_up_time);
    check("rst_count_cyc", v1, last_up_cyc - c_rel);

    // Monotonic: gap equals cycle gap of the UP handshakes
    t1 = last_up_time; c1 = last_up_cyc;
    repeat (10) @(negedge clk);
    read64(v2);
    check("mono_gap", v2 - v1, last_up_cyc - c1);
    check("mono_model", v2 - t1, last_up_time - t1);

    // Table of mapped/unmapped addresses
    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].addr, d, r);
      check("tbl_resp", 64'(r), 64'(vecs[i].resp));
      if (vecs[i].resp != 2'b00) check("tbl_zero", 64'(d), 64'd0);
    end

    // Carry across the 32-bit word boundary
    @(negedge clk);
    force dut.u_mtime.mtime_d = 64'h0000_0000_ffff_fffe;
    load_v = 64'h0000_0000_ffff_fffe; load_en = 1'b1;
    @(negedge clk);
    release dut.u_mtime.mtime_d;
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    read64(v1);
    check("carry_value", v1, 64'h0000_0001_0000_0001);

    // Wrap from all-ones to zero
    @(negedge clk);
    force dut.u_mtime.mtime_d = 64'hffff_ffff_ffff_ffff;
    load_v = 64'hffff_ffff_ffff_ffff; load_en = 1'b1;
    @(negedge clk);
    release dut.u_mtime.mtime_d;
    load_en = 1'b0;
    read64(v1);
    check("wrap_value", v1, 64'd0);

    // Stall with rready low
    start_read(UP_ADDR);
    d0 = m_snap[63:32];
    for (int i = 0; i < 5; i++) begin
      check("stall_state", {61'd0, rvalid_o, arready_o, rlast_o}, 64'd5);
      check("stall_data", 64'(rdata_o), 64'(d0));
      @(negedge clk);
    end
    finish_read(d, r);

    // Write path: lone address not accepted, full write acknowledged and discarded
    @(negedge clk);
    awaddr = LO_ADDR; wdata = 32'hdeadbeef; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    check("aw_only_nobvalid", {63'd0, bvalid_o}, 64'd0);
    wvalid = 1'b1;
    check("w_ready", {62'd0, awready_o, wready_o}, 64'd3);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_set", {58'd0, bvalid_o, awready_o, wready_o, bresp_o, 1'b0}, {58'd0, 6'b100000});
    check("bid", 64'(bid), 64'd0);
    repeat (2) @(negedge clk);
    check("bvalid_hold", {63'd0, bvalid_o}, 64'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done", {61'd0, bvalid_o, awready_o, wready_o}, 64'd3);
    read64(v1);
    check("write_no_effect", v1, last_up_time);

    // Reset while a read response is pending
    start_read(UP_ADDR);
    @(negedge clk);
    check("pend_rvalid", {63'd0, rvalid_o}, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    m_snap = '0;
    @(negedge clk);
    rst = 1'b0;
    c_rel = cyc;
    check("rst_mid", {62'd0, rvalid_o, arready_o}, 64'd1);
    do_read(LO_ADDR, d, r);
    check("rst_snap_clear", 64'(d), 64'd0);
    read64(v1);
    check("rst_mid_count", v1, last_up_cyc - c_rel);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
